// File: rtl/sev_seg_monitor.sv
// Loop-back observer for a multiplexed active-low seven-segment bus: waits for each
// digit to dwell, decodes it back to a nibble and publishes whole frames.
module sev_seg_monitor #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segs_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    value_valid,
  output logic                    frame_valid
);

  localparam int SW   = NUM_DIGITS + 7;
  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int IDXW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]         s_q;
  logic [SW-1:0]         p_q;
  logic [CW-1:0]         cnt;
  logic [NUM_DIGITS-1:0] seen;
  logic [3:0]            shadow [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] shadow_err;

  logic [NUM_DIGITS-1:0] s_an;
  logic [6:0]            s_segs;
  logic                  stable;
  logic                  capture;
  logic                  frame_done;
  logic [IDXW-1:0]       sel_idx;
  logic [3:0]            dec_nibble;
  logic                  dec_legal;

  assign s_an       = s_q[SW-1:7];
  assign s_segs     = s_q[6:0];
  assign stable     = (s_q == p_q) && $onehot(~s_an);
  assign capture    = stable && (cnt == CNT_LAST);
  assign frame_done = &seen;

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!s_an[k]) sel_idx = IDXW'(k);
    end
  end

  // Inverse of the board's hex-to-segment table; anything else is flagged illegal.
  always_comb begin
    dec_nibble = 4'h0;
    dec_legal  = 1'b1;
    case (s_segs)
      7'b1000000: dec_nibble = 4'h0;
      7'b1111001: dec_nibble = 4'h1;
      7'b0100100: dec_nibble = 4'h2;
      7'b0110000: dec_nibble = 4'h3;
      7'b0011001: dec_nibble = 4'h4;
      7'b0010010: dec_nibble = 4'h5;
      7'b0000010: dec_nibble = 4'h6;
      7'b1111000: dec_nibble = 4'h7;
      7'b0000000: dec_nibble = 4'h8;
      7'b0010000: dec_nibble = 4'h9;
      7'b0001000: dec_nibble = 4'hA;
      7'b0000011: dec_nibble = 4'hB;
      7'b1000110: dec_nibble = 4'hC;
      7'b0100001: dec_nibble = 4'hD;
      7'b0000110: dec_nibble = 4'hE;
      7'b0001110: dec_nibble = 4'hF;
      default:    dec_legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
      p_q <= '0;
      cnt <= '0;
    end else begin
      s_q <= {an_in, segs_in};
      p_q <= s_q;
      if (!stable)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  // Saturating cnt means a long-held digit is captured once, not every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen       <= '0;
      shadow_err <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) shadow[k] <= 4'h0;
    end else begin
      if (frame_done) seen <= '0;
      if (capture) begin
        seen[sel_idx] <= 1'b1;
        if (dec_legal) begin
          shadow[sel_idx]     <= dec_nibble;
          shadow_err[sel_idx] <= 1'b0;
        end else begin
          shadow_err[sel_idx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_out   <= '0;
      digit_err   <= '0;
      value_valid <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        for (int k = 0; k < NUM_DIGITS; k++) value_out[4*k +: 4] <= shadow[k];
        digit_err   <= shadow_err;
        value_valid <= 1'b1;
      end
    end
  end

endmodule
